// File: rtl/maxpool_stream.sv
// maxpool_stream: streaming 2x2/stride-2 max pool (or 1:1 bypass) with optional ReLU.
// Partial row maxima of even rows are parked in a half-width line buffer.
module maxpool_stream #(
    parameter int CHANNELS = 32,
    parameter int DATA_W   = 8,
    parameter int MAX_COL  = 256,
    parameter int SIGNED   = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [8:0]                   col,
    input  logic [8:0]                   row,
    input  logic                         pool_en,
    input  logic                         relu_en,
    input  logic [CHANNELS*DATA_W-1:0]   in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [CHANNELS*DATA_W-1:0]   out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         busy,
    output logic                         done
);
    localparam int W  = CHANNELS * DATA_W;
    localparam int AW = $clog2(MAX_COL / 2);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t         state_q, state_d;
    logic [8:0]     c_q, c_d, r_q, r_d, col_q, col_d, row_q, row_d;
    logic           pool_q, pool_d, relu_q, relu_d, ov_q, ov_d;
    logic [W-1:0]   hreg_q, hreg_d, od_q, od_d, lb_wd, lb_rd, res;
    logic [W-1:0]   lb_q [MAX_COL/2];
    logic [AW-1:0]  lb_idx;
    logic           beat, last_c, last, produce, lb_we;

    function automatic logic [DATA_W-1:0] mx(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        return ((SIGNED != 0) ? ($signed(a) > $signed(b)) : (a > b)) ? a : b;
    endfunction

    function automatic logic [DATA_W-1:0] clamp(input logic [DATA_W-1:0] v);
        return (relu_q && SIGNED != 0 && v[DATA_W-1]) ? '0 : v;
    endfunction

    assign beat    = in_valid & in_ready;
    assign last_c  = c_q == col_q - 9'd1;
    assign last    = last_c & (r_q == row_q - 9'd1);
    assign produce = beat & (~pool_q | (r_q[0] & c_q[0]));
    assign lb_idx  = c_q[AW:1];
    assign lb_rd   = lb_q[lb_idx];
    assign lb_we   = beat & pool_q & ~r_q[0] & c_q[0];

    always_ff @(posedge clk)
        state_q <= rst ? IDLE : state_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? RUN : IDLE;
            RUN:     state_d = (beat & last) ? DRAIN : RUN;
            DRAIN:   state_d = (~ov_q | out_ready) ? DONE : DRAIN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q == RUN) & (~ov_q | out_ready);
        busy     = (state_q == RUN) | (state_q == DRAIN);
        done     = state_q == DONE;
    end

    // Per-channel: row max of (hreg, pixel) feeds both the line buffer and the 2x2 max.
    always_comb begin
        lb_wd = '0;
        res   = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            lb_wd[k*DATA_W +: DATA_W] = mx(hreg_q[k*DATA_W +: DATA_W], in_data[k*DATA_W +: DATA_W]);
            res[k*DATA_W +: DATA_W]   = clamp(pool_q ? mx(lb_rd[k*DATA_W +: DATA_W], lb_wd[k*DATA_W +: DATA_W])
                                                     : in_data[k*DATA_W +: DATA_W]);
        end
    end

    always_comb begin
        c_d    = c_q;
        r_d    = r_q;
        col_d  = col_q;
        row_d  = row_q;
        pool_d = pool_q;
        relu_d = relu_q;
        hreg_d = hreg_q;
        od_d   = od_q;
        ov_d   = ov_q & ~out_ready;
        if (start && state_q == IDLE) begin
            col_d  = col;
            row_d  = row;
            pool_d = pool_en;
            relu_d = relu_en;
            c_d    = '0;
            r_d    = '0;
        end
        if (beat) begin
            c_d = last_c ? 9'd0 : c_q + 9'd1;
            r_d = last_c ? r_q + 9'd1 : r_q;
            if (pool_q && !c_q[0]) hreg_d = in_data;
        end
        if (produce) begin
            od_d = res;
            ov_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            c_q    <= '0;
            r_q    <= '0;
            col_q  <= '0;
            row_q  <= '0;
            pool_q <= 1'b0;
            relu_q <= 1'b0;
            hreg_q <= '0;
            od_q   <= '0;
            ov_q   <= 1'b0;
        end else begin
            c_q    <= c_d;
            r_q    <= r_d;
            col_q  <= col_d;
            row_q  <= row_d;
            pool_q <= pool_d;
            relu_q <= relu_d;
            hreg_q <= hreg_d;
            od_q   <= od_d;
            ov_q   <= ov_d;
        end
    end

    // Deliberately not reset: every entry is written in an even row before it is read.
    always_ff @(posedge clk)
        if (lb_we) lb_q[lb_idx] <= lb_wd;

    assign out_data  = od_q;
    assign out_valid = ov_q;
endmodule

// File: tb/tb_maxpool_stream.sv
// tb_maxpool_stream: directed checks of pooling, ReLU, odd sizes, backpressure, bypass and reset.
// A signed and an unsigned instance share all inputs.
module tb_maxpool_stream;
    logic        clk = 1'b0;
    logic        rst, start, pool_en, relu_en, in_valid, out_ready;
    logic [8:0]  col, row;
    logic [15:0] in_data, od_s, od_u;
    logic        ir_s, ov_s, busy_s, done_s, ir_u, ov_u, busy_u, done_u;
    int          checks = 0, errors = 0;
    logic [15:0] px [64];
    logic [15:0] got_s[$], got_u[$], exp_q[$];
    int          first_in, first_out, last_out, done_cyc, n_beats;

    always #5 clk = ~clk;

    maxpool_stream #(.CHANNELS(2), .DATA_W(8), .MAX_COL(16), .SIGNED(1)) dut_s (
        .clk(clk), .rst(rst), .start(start), .col(col), .row(row), .pool_en(pool_en),
        .relu_en(relu_en), .in_data(in_data), .in_valid(in_valid), .in_ready(ir_s),
        .out_data(od_s), .out_valid(ov_s), .out_ready(out_ready), .busy(busy_s), .done(done_s));

    maxpool_stream #(.CHANNELS(2), .DATA_W(8), .MAX_COL(16), .SIGNED(0)) dut_u (
        .clk(clk), .rst(rst), .start(start), .col(col), .row(row), .pool_en(pool_en),
        .relu_en(relu_en), .in_data(in_data), .in_valid(in_valid), .in_ready(ir_u),
        .out_data(od_u), .out_valid(ov_u), .out_ready(out_ready), .busy(busy_u), .done(done_u));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_q(input string tag, input bit u);
        logic [15:0] g;
        chk({tag, "_count"}, u ? 32'(got_u.size()) : 32'(got_s.size()), 32'(exp_q.size()));
        foreach (exp_q[i]) begin
            g = 'x;
            if (u && i < got_u.size()) g = got_u[i];
            if (!u && i < got_s.size()) g = got_s[i];
            chk($sformatf("%s_%0d", tag, i), 32'(g), 32'(exp_q[i]));
        end
    endtask

    // Streams px[0..cols*rows-1]; optional one-shot stall of stall_len cycles on the
    // first valid output; abort_after >= 0 stops feeding after that many beats.
    task automatic frame(input int cols, input int rows, input bit pool, input bit relu,
                         input int stall_len, input int abort_after);
        int          idx = 0, cyc = 0, stall_left = 0;
        bit          stalled = 0, fin = 0;
        logic [15:0] held = '0;
        got_s.delete();
        got_u.delete();
        first_in = -1; first_out = -1; last_out = -1; done_cyc = -1;
        @(negedge clk);
        start = 1'b1; col = 9'(cols); row = 9'(rows); pool_en = pool; relu_en = relu;
        @(negedge clk);
        start = 1'b0;
        while (!fin && cyc < 400) begin
            if (stall_len > 0 && !stalled && ov_s) begin
                stalled = 1; stall_left = stall_len; held = od_s;
            end
            out_ready = (stall_left == 0);
            in_valid  = (idx < cols * rows) && (idx != abort_after);
            in_data   = px[idx];
            #1;
            if (stall_left > 0) begin
                chk("stall_in_ready", 32'(ir_s), 32'd0);
                chk("stall_out_valid", 32'(ov_s), 32'd1);
                chk("stall_out_data", 32'(od_s), 32'(held));
                stall_left--;
            end
            if (ov_s && out_ready) begin
                got_s.push_back(od_s);
                got_u.push_back(od_u);
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
            end
            if (in_valid && ir_s) begin
                if (first_in < 0) first_in = cyc;
                idx++;
            end
            if (done_s) begin done_cyc = cyc; fin = 1; end
            if (abort_after >= 0 && idx == abort_after) fin = 1;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        n_beats = idx;
        chk("frame_finished", 32'(fin), 32'd1);
    endtask

    task automatic exp_pool4(input bit relu);
        exp_q.delete();
        exp_q.push_back(16'h0005);
        exp_q.push_back(relu ? 16'h0007 : 16'hFE07);
        exp_q.push_back(relu ? 16'h000D : 16'hF80D);
        exp_q.push_back(relu ? 16'h000F : 16'hF60F);
    endtask

    task automatic fill_px();
        for (int i = 0; i < 64; i++) px[i] = {8'(-i), 8'(i)};
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        col = '0; row = '0; pool_en = 1'b0; relu_en = 1'b0; in_data = '0;
        fill_px();
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(ov_s), 32'd0);
        chk("rst_out_data", 32'(od_s), 32'd0);
        chk("rst_in_ready", 32'(ir_s), 32'd0);
        chk("rst_busy", 32'(busy_s), 32'd0);
        chk("rst_done", 32'(done_s), 32'd0);
        rst = 1'b0;

        frame(4, 4, 1, 0, 0, -1);
        exp_pool4(0);
        check_q("pool4", 0);
        chk("done_latency", 32'(done_cyc), 32'(last_out + 1));
        chk("busy_after", 32'(busy_s), 32'd0);
        chk("done_pulse", 32'(done_s), 32'd0);

        frame(4, 4, 1, 1, 0, -1);
        exp_pool4(1);
        check_q("relu4", 0);

        frame(5, 3, 1, 0, 0, -1);
        exp_q.delete();
        exp_q.push_back(16'h0006);
        exp_q.push_back(16'hFE08);
        check_q("pool5x3", 0);
        chk("beats5x3", 32'(n_beats), 32'd15);

        frame(4, 4, 1, 0, 5, -1);
        exp_pool4(0);
        check_q("backpressure", 0);

        for (int i = 0; i < 6; i++) px[i] = {8'(i), 8'hFF};
        frame(3, 2, 0, 1, 0, -1);
        exp_q.delete();
        for (int i = 0; i < 6; i++) exp_q.push_back({8'(i), 8'hFF});
        check_q("bypass_u", 1);
        exp_q.delete();
        for (int i = 0; i < 6; i++) exp_q.push_back({8'(i), 8'h00});
        check_q("bypass_s_relu", 0);
        chk("bypass_latency", 32'(first_out), 32'(first_in + 1));
        fill_px();

        frame(4, 4, 1, 0, 0, 7);
        chk("abort_beats", 32'(n_beats), 32'd7);
        chk("pre_rst_data", 32'(od_s), 32'h0005);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_out_valid", 32'(ov_s), 32'd0);
        chk("mid_rst_out_data", 32'(od_s), 32'd0);
        chk("mid_rst_busy", 32'(busy_s), 32'd0);
        chk("mid_rst_in_ready", 32'(ir_s), 32'd0);
        rst = 1'b0;
        frame(4, 4, 1, 0, 0, -1);
        exp_pool4(0);
        check_q("after_rst", 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
